// File: rtl/mii_frame_receiver_if.sv
// MII receive-side signal bundle: the PHY drives it (master), the frame receiver samples it (slave).
interface mii_frame_receiver_if;
    logic [3:0] rxd;
    logic       rx_dv;
    logic       rx_er;

    modport master (output rxd, rx_dv, rx_er);
    modport slave  (input  rxd, rx_dv, rx_er);
endinterface

// File: rtl/mii_frame_receiver.sv
// MII frame receiver: strips preamble/SFD, writes post-SFD bytes to frame RAM, checks FCS and length.
// Define RX_MAC_FILTER_EN to add destination-MAC filtering (BOARD_MAC or broadcast) and mac_miss.
module mii_frame_receiver #(
    parameter int unsigned MAX_BYTES = 1518,
    parameter int unsigned MIN_BYTES = 64,
    parameter int unsigned ADDR_W    = 11
`ifdef RX_MAC_FILTER_EN
    ,
    parameter logic [47:0] BOARD_MAC = 48'h0000_0000_0000
`endif
) (
    input  logic                 clock,
    input  logic                 sclr,
    mii_frame_receiver_if.slave  mii,
    output logic [ADDR_W-1:0]    ram_wraddr,
    output logic [7:0]           ram_data,
    output logic                 ram_wren,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [15:0]          frame_len,
    output logic                 crc_err,
    output logic                 len_err,
    output logic                 phy_err,
    output logic [15:0]          drop_cnt
`ifdef RX_MAC_FILTER_EN
    ,
    output logic                 mac_miss
`endif
);

    typedef enum logic [2:0] {StIdle, StPre, StData, StDrop, StEnd} state_e;

    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
    localparam logic [15:0] MaxLen     = 16'(MAX_BYTES);
    localparam logic [15:0] MinLen     = 16'(MIN_BYTES);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    state_e      state;
    logic [3:0]  nib_lo;
    logic        have_lo;
    logic [15:0] byte_cnt;
    logic [31:0] crc;
    logic        phy_seen;
    logic        oversize;
    logic        early_drop;
    logic [7:0]  cur_byte;
    logic [31:0] crc_upd;
    logic        end_crc_err;
    logic        end_len_err;
    logic        end_bad;

    assign cur_byte    = {mii.rxd, nib_lo};
    assign crc_upd     = crc_byte(crc, cur_byte);
    assign end_crc_err = (crc != CrcResidue);
    assign end_len_err = early_drop | oversize | have_lo | (byte_cnt < MinLen);
    assign end_bad     = end_crc_err | end_len_err | phy_seen;

`ifdef RX_MAC_FILTER_EN
    logic [47:0] mac_ref;
    logic        uni_hit;
    logic        bc_hit;
    logic        end_mac_miss;
    assign end_mac_miss = ~(uni_hit | bc_hit);
`endif

    always_ff @(posedge clock or posedge sclr) begin
        if (sclr) begin
            state      <= StIdle;
            nib_lo     <= '0;
            have_lo    <= 1'b0;
            byte_cnt   <= '0;
            crc        <= '1;
            phy_seen   <= 1'b0;
            oversize   <= 1'b0;
            early_drop <= 1'b0;
            ram_wraddr <= '0;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_len  <= '0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            phy_err    <= 1'b0;
            drop_cnt   <= '0;
`ifdef RX_MAC_FILTER_EN
            mac_ref    <= '0;
            uni_hit    <= 1'b0;
            bc_hit     <= 1'b0;
            mac_miss   <= 1'b0;
`endif
        end else begin
            ram_wren   <= 1'b0;
            frame_done <= 1'b0;
            if (mii.rx_dv && mii.rx_er) phy_seen <= 1'b1;

            unique case (state)
                // END behaves like IDLE so a back-to-back preamble nibble is not lost.
                StIdle, StEnd: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                    if (mii.rx_dv) begin
                        state      <= (mii.rxd == 4'h5) ? StPre : StDrop;
                        early_drop <= (mii.rxd != 4'h5);
                        busy       <= 1'b1;
                        nib_lo     <= '0;
                        have_lo    <= 1'b0;
                        byte_cnt   <= '0;
                        crc        <= '1;
                        oversize   <= 1'b0;
                        phy_seen   <= mii.rx_er;
`ifdef RX_MAC_FILTER_EN
                        mac_ref    <= BOARD_MAC;
                        uni_hit    <= 1'b1;
                        bc_hit     <= 1'b1;
`endif
                    end
                end
                StPre: begin
                    if (!mii.rx_dv) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end else if (mii.rxd == 4'hD) begin
                        state <= StData;
                    end else if (mii.rxd != 4'h5) begin
                        state      <= StDrop;
                        early_drop <= 1'b1;
                    end
                end
                StData, StDrop: begin
                    if (!mii.rx_dv) begin
                        state      <= StEnd;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_len  <= byte_cnt;
                        crc_err    <= end_crc_err;
                        len_err    <= end_len_err;
                        phy_err    <= phy_seen;
`ifdef RX_MAC_FILTER_EN
                        frame_ok   <= ~end_bad & ~end_mac_miss;
                        mac_miss   <= end_mac_miss;
`else
                        frame_ok   <= ~end_bad;
`endif
                        if (end_bad && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end else if (state == StData) begin
                        if (!have_lo) begin
                            nib_lo  <= mii.rxd;
                            have_lo <= 1'b1;
                        end else begin
                            have_lo <= 1'b0;
                            if (byte_cnt == MaxLen) begin
                                oversize <= 1'b1;
                                state    <= StDrop;
                            end else begin
                                ram_wren   <= 1'b1;
                                ram_data   <= cur_byte;
                                ram_wraddr <= byte_cnt[ADDR_W-1:0];
                                byte_cnt   <= byte_cnt + 16'd1;
                                crc        <= crc_upd;
`ifdef RX_MAC_FILTER_EN
                                if (byte_cnt < 16'd6) begin
                                    if (cur_byte != mac_ref[47:40]) uni_hit <= 1'b0;
                                    if (cur_byte != 8'hFF) bc_hit <= 1'b0;
                                    mac_ref <= {mac_ref[39:0], 8'h00};
                                end
`endif
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mii_frame_receiver.sv
// Directed bench for mii_frame_receiver: good/bad-FCS, runt, odd-nibble, rx_er, oversize, reset.
module tb_mii_frame_receiver;

    localparam int unsigned ADDR_W = 11;

    logic              clock = 1'b0;
    logic              sclr;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [7:0]        ram_data;
    logic              ram_wren;
    logic              busy;
    logic              frame_done;
    logic              frame_ok;
    logic [15:0]       frame_len;
    logic              crc_err;
    logic              len_err;
    logic              phy_err;
    logic [15:0]       drop_cnt;

    mii_frame_receiver_if mii ();

    mii_frame_receiver #(
        .MAX_BYTES (1518),
        .MIN_BYTES (64),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock      (clock),
        .sclr       (sclr),
        .mii        (mii),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_len  (frame_len),
        .crc_err    (crc_err),
        .len_err    (len_err),
        .phy_err    (phy_err),
        .drop_cnt   (drop_cnt)
    );

    always #4 clock = ~clock;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write/status monitor, sampled on the falling edge.
    logic [7:0]        mem [0:2047];
    int                wr_cnt = 0;
    int                done_cnt = 0;
    int                busy_cnt = 0;
    int                addr_bad = 0;
    int                wr_expect = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              cap_ok, cap_crc, cap_len_err, cap_phy;
    logic [15:0]       cap_len;

    always @(negedge clock) begin
        if (sclr) wr_expect = 0;
        if (busy) busy_cnt++;
        if (ram_wren) begin
            if (int'(ram_wraddr) != wr_expect) addr_bad++;
            wr_expect = int'(ram_wraddr) + 1;
            mem[ram_wraddr] = ram_data;
            last_addr = ram_wraddr;
            wr_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            wr_expect   = 0;
            cap_ok      = frame_ok;
            cap_crc     = crc_err;
            cap_len_err = len_err;
            cap_phy     = phy_err;
            cap_len     = frame_len;
        end
    end

    logic [7:0] frm [0:1599];
    int         frm_len;
    int         wr_base, done_base, busy_base;

    // Payload bytes then the Ethernet FCS (complemented CRC-32, sent LSB byte first).
    task automatic build(input int n_pay, input bit add_fcs);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n_pay; i++) begin
            frm[i] = 8'((i * 37 + 11) & 255);
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        frm_len = n_pay;
        if (add_fcs) begin
            c = ~c;
            for (int k = 0; k < 4; k++) frm[n_pay + k] = c[8*k +: 8];
            frm_len = n_pay + 4;
        end
    endtask

    task automatic drive(input logic [3:0] n, input logic er);
        @(negedge clock);
        mii.rxd   = n;
        mii.rx_dv = 1'b1;
        mii.rx_er = er;
    endtask

    task automatic drive_idle();
        @(negedge clock);
        mii.rxd   = 4'h0;
        mii.rx_dv = 1'b0;
        mii.rx_er = 1'b0;
    endtask

    task automatic send_frame(input int er_byte, input bit odd_nib, input int stop_byte);
        for (int i = 0; i < 15; i++) drive(4'h5, 1'b0);
        drive(4'hD, 1'b0);
        for (int i = 0; i < frm_len; i++) begin
            if (i == stop_byte) return;
            drive(frm[i][3:0], i == er_byte);
            drive(frm[i][7:4], i == er_byte);
        end
        if (odd_nib) drive(4'hA, 1'b0);
        drive_idle();
    endtask

    task automatic snap();
        wr_base   = wr_cnt;
        done_base = done_cnt;
        busy_base = busy_cnt;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done_cnt != done_base) break;
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic run_frame(input int er_byte, input bit odd_nib);
        snap();
        send_frame(er_byte, odd_nib, -1);
        wait_done();
    endtask

    function automatic int data_mismatches(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) if (mem[i] !== frm[i]) bad++;
        return bad;
    endfunction

    initial begin
        sclr      = 1'b1;
        mii.rxd   = 4'h0;
        mii.rx_dv = 1'b0;
        mii.rx_er = 1'b0;
        repeat (3) @(negedge clock);
        sclr = 1'b0;
        @(negedge clock);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        check_eq("rst_wren", 32'(ram_wren), 0);
        check_eq("rst_addr", 32'(ram_wraddr), 0);
        check_eq("rst_ok", 32'(frame_ok), 0);
        check_eq("rst_drop", 32'(drop_cnt), 0);

        // Good 64-byte frame.
        build(60, 1'b1);
        run_frame(-1, 1'b0);
        check_eq("good_wr", 32'(wr_cnt - wr_base), 64);
        check_eq("good_addr_seq", 32'(addr_bad), 0);
        check_eq("good_last_addr", 32'(last_addr), 63);
        check_eq("good_data", 32'(data_mismatches(64)), 0);
        check_eq("good_done", 32'(done_cnt - done_base), 1);
        check_eq("good_ok", 32'(cap_ok), 1);
        check_eq("good_len", 32'(cap_len), 64);
        check_eq("good_crc", 32'(cap_crc), 0);
        check_eq("good_len_err", 32'(cap_len_err), 0);
        check_eq("good_phy", 32'(cap_phy), 0);
        check_eq("good_drop", 32'(drop_cnt), 0);
        check_eq("good_busy_seen", 32'(busy_cnt > busy_base + 100), 1);
        check_eq("good_busy_end", 32'(busy), 0);

        // One FCS bit flipped.
        frm[63] = frm[63] ^ 8'h01;
        run_frame(-1, 1'b0);
        check_eq("fcs_crc", 32'(cap_crc), 1);
        check_eq("fcs_ok", 32'(cap_ok), 0);
        check_eq("fcs_len_err", 32'(cap_len_err), 0);
        check_eq("fcs_drop", 32'(drop_cnt), 1);

        // Runt: 40 payload + FCS.
        build(40, 1'b1);
        run_frame(-1, 1'b0);
        check_eq("runt_len_err", 32'(cap_len_err), 1);
        check_eq("runt_len", 32'(cap_len), 44);
        check_eq("runt_crc", 32'(cap_crc), 0);
        check_eq("runt_wr", 32'(wr_cnt - wr_base), 44);
        check_eq("runt_drop", 32'(drop_cnt), 2);

        // Good frame plus one trailing nibble.
        build(60, 1'b1);
        run_frame(-1, 1'b1);
        check_eq("odd_len_err", 32'(cap_len_err), 1);
        check_eq("odd_crc", 32'(cap_crc), 0);
        check_eq("odd_len", 32'(cap_len), 64);
        check_eq("odd_ok", 32'(cap_ok), 0);
        check_eq("odd_drop", 32'(drop_cnt), 3);

        // rx_er during byte 20.
        run_frame(20, 1'b0);
        check_eq("phy_err", 32'(cap_phy), 1);
        check_eq("phy_wr", 32'(wr_cnt - wr_base), 64);
        check_eq("phy_data", 32'(data_mismatches(64)), 0);
        check_eq("phy_ok", 32'(cap_ok), 0);
        check_eq("phy_crc", 32'(cap_crc), 0);
        check_eq("phy_drop", 32'(drop_cnt), 4);

        // First nibble is not preamble: dropped, reported with zero length.
        snap();
        drive(4'h3, 1'b0);
        drive(4'h5, 1'b0);
        drive(4'hD, 1'b0);
        drive(4'h1, 1'b0);
        drive_idle();
        wait_done();
        check_eq("drop_done", 32'(done_cnt - done_base), 1);
        check_eq("drop_len_err", 32'(cap_len_err), 1);
        check_eq("drop_len", 32'(cap_len), 0);
        check_eq("drop_wr", 32'(wr_cnt - wr_base), 0);
        check_eq("drop_drop", 32'(drop_cnt), 5);

        // Oversize: 1600 bytes.
        build(1600, 1'b0);
        run_frame(-1, 1'b0);
        check_eq("big_wr", 32'(wr_cnt - wr_base), 1518);
        check_eq("big_last_addr", 32'(last_addr), 1517);
        check_eq("big_len_err", 32'(cap_len_err), 1);
        check_eq("big_len", 32'(cap_len), 1518);
        check_eq("big_drop", 32'(drop_cnt), 6);
        check_eq("addr_seq_all", 32'(addr_bad), 0);

        // Reset in the middle of a frame.
        build(60, 1'b1);
        snap();
        send_frame(-1, 1'b0, 10);
        @(negedge clock);
        check_eq("mid_busy", 32'(busy), 1);
        sclr      = 1'b1;
        mii.rx_dv = 1'b0;
        #1;
        check_eq("srst_busy", 32'(busy), 0);
        check_eq("srst_addr", 32'(ram_wraddr), 0);
        check_eq("srst_len", 32'(frame_len), 0);
        check_eq("srst_drop", 32'(drop_cnt), 0);
        check_eq("srst_len_err", 32'(len_err), 0);
        repeat (2) @(negedge clock);
        sclr = 1'b0;
        repeat (10) @(negedge clock);
        check_eq("srst_no_done", 32'(done_cnt - done_base), 0);
        check_eq("srst_drop_after", 32'(drop_cnt), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mii_frame_receiver.md
Name: mii_frame_receiver

Overview:
- MII receive counterpart of the board's nibble-wide Ethernet transmitter.
- Strips preamble/SFD, assembles bytes low-nibble-first, streams every post-SFD byte (including FCS) into the receive frame RAM, and checks CRC-32.
- Emits a one-cycle per-frame status strobe with length and error flags for the downstream UDP command parser.

Parameters:
- MAX_BYTES, 1518, maximum accepted frame length in bytes (DA through FCS).
- MIN_BYTES, 64, minimum accepted frame length in bytes (DA through FCS).
- ADDR_W, 11, frame RAM write-address width; must satisfy 2^ADDR_W >= MAX_BYTES.
- BOARD_MAC, 48'h0000_0000_0000, unicast address used only when the filter option is compiled in.

Ports:
- clock  in  1  125 MHz-domain receive clock; rxd/rx_dv/rx_er are already synchronous to it.
- sclr  in  1  reset, asynchronous, active-high.
- rxd  in  4  MII receive nibble.
- rx_dv  in  1  receive data valid.
- rx_er  in  1  receive error.
- ram_wraddr  out  ADDR_W  byte address in frame RAM, restarts at 0 each frame.
- ram_data  out  8  assembled byte.
- ram_wren  out  1  write strobe, one cycle per byte.
- busy  out  1  high from first preamble nibble until frame_done.
- frame_done  out  1  one-cycle end-of-frame strobe.
- frame_ok  out  1  frame passed all checks; valid while frame_done is high.
- frame_len  out  16  byte count DA through FCS; held until the next frame_done.
- crc_err  out  1  sticky per frame; valid with frame_done.
- len_err  out  1  runt, oversize or odd nibble count; valid with frame_done.
- phy_err  out  1  rx_er seen during the frame; valid with frame_done.
- drop_cnt  out  16  count of frames with frame_ok=0; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; CRC register 32'hFFFFFFFF.
- IDLE -> PRE when rx_dv=1 and rxd=4'h5.
- IDLE -> DROP when rx_dv=1 and rxd is any other value.
- PRE: stays on 4'h5.
- PRE -> DATA on 4'hD after at least one 4'h5. No frame_done for a frame discarded in PRE; drop_cnt increments.
- PRE -> DROP on any other nibble.
- PRE -> IDLE if rx_dv falls.
- DATA byte assembly: first nibble -> byte[3:0], second nibble -> byte[7:4].
- ram_wren pulses the cycle after the high nibble is sampled (latency 1). ram_data and ram_wraddr are valid with ram_wren; ram_wraddr increments after each write.
- CRC-32: polynomial 0x04C11DB7, reflected, init FFFFFFFF, updated per byte over all bytes including FCS. A good frame leaves the register at 32'hDEBB20E3; any other value sets crc_err.
- Oversize: byte count reaching MAX_BYTES stops RAM writes (address never exceeds MAX_BYTES-1). len_err is set and the state moves to DROP.
- DATA/DROP -> END on the first cycle sampled with rx_dv=0.
- END (one cycle): frame_done=1 and the status outputs update.
  - len_err is set if bytes < MIN_BYTES, or a high nibble is pending (odd nibble count), or oversize occurred.
  - frame_ok = ~crc_err & ~len_err & ~phy_err.
  - drop_cnt increments when frame_ok=0.
  - Return to IDLE.
- rx_er=1 with rx_dv=1 in any state sets phy_err. Reception continues.
- DROP: no RAM writes. Waits for rx_dv=0, then goes to END.
  - DROP entered from IDLE reports len_err=1 and frame_len=0.
- Back-to-back frames: the END cycle may coincide with rx_dv=1 of the next preamble. That nibble is evaluated by the IDLE rules in the same cycle.
- Reset mid-frame: returns to IDLE immediately with no frame_done. The partial frame is abandoned in RAM, and drop_cnt is not incremented.

Optional Feature:
- Macro: RX_MAC_FILTER_EN.
- Defined: destination bytes 0-5 are compared with BOARD_MAC (byte 0 = BOARD_MAC[47:40]) and with FF:FF:FF:FF:FF:FF.
  - On mismatch, writes continue to completion, frame_done still fires, and frame_ok=0 with an added output mac_miss=1.
  - mac_miss-only frames do not increment drop_cnt.
- Undefined: no comparison, mac_miss port absent, all frames are eligible for frame_ok.

Test Plan:
- Good frame: 15x4'h5, 4'hD, 60 payload bytes + correct FCS -> 64 ram_wren pulses at addresses 0..63, low nibble first; frame_done with frame_ok=1, frame_len=64, drop_cnt=0.
- Same frame with one FCS bit flipped -> crc_err=1, frame_ok=0, drop_cnt=1.
- Runt: 40 bytes + valid FCS -> len_err=1, frame_len=44.
- Odd nibbles: good frame plus one trailing nibble -> len_err=1.
- rx_er pulsed at byte 20 of a good frame -> phy_err=1, all 64 bytes still written, frame_ok=0.
- Oversize: 1600 bytes -> last write at address 1517, len_err=1; then sclr asserted mid-frame on a following frame -> all outputs 0 immediately, no frame_done, drop_cnt unchanged.
